// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, host request and received-byte signals of the UART receiver.
interface uart_rx_if;
    logic       rx;
    logic       go;
    logic [7:0] data;
    logic       dr;
    logic       ferr;
    modport master (output rx, go, input data, dr, ferr);
    modport slave (input rx, go, output data, dr, ferr);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a go/dr host handshake and a one-cycle framing-error pulse.
module uart_rx #(
    parameter int CLK_FREQ  = 66_000_000,
    parameter int BAUD_RATE = 9600
) (
    input logic       clk,
    input logic       rst,
    uart_rx_if.slave  bus
);
    localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
    localparam int HALF     = BIT_TIME / 2;
    localparam int CW       = BIT_TIME > 1 ? $clog2(BIT_TIME) : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(BIT_TIME - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_GO_LOW} state_t;

    state_t        state;
    logic          s1, rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shift, data_r;
    logic          dr_r, ferr_r;

    assign bus.data = data_r;
    assign bus.dr   = dr_r;
    assign bus.ferr = ferr_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            s1     <= 1'b1;
            rxs    <= 1'b1;
            cnt    <= '0;
            bitn   <= '0;
            shift  <= '0;
            data_r <= '0;
            dr_r   <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            s1     <= bus.rx;
            rxs    <= s1;
            ferr_r <= 1'b0;
            case (state)
                IDLE: if (bus.go && !rxs) begin
                    cnt   <= '0;
                    state <= START;
                end
                // mid-start-bit recheck rejects glitches shorter than half a bit
                START: if (cnt == HALF_END) begin
                    cnt   <= '0;
                    bitn  <= '0;
                    state <= rxs ? IDLE : DATA;
                end else cnt <= cnt + CW'(1);
                DATA: if (cnt == BIT_END) begin
                    cnt   <= '0;
                    shift <= {rxs, shift[7:1]};
                    bitn  <= bitn + 3'd1;
                    if (bitn == 3'd7) state <= STOP;
                end else cnt <= cnt + CW'(1);
                STOP: if (cnt == BIT_END) begin
                    cnt <= '0;
                    if (rxs) begin
                        data_r <= shift;
                        dr_r   <= 1'b1;
                        state  <= WAIT_GO_LOW;
                    end else begin
                        ferr_r <= 1'b1;
                        state  <= IDLE;
                    end
                end else cnt <= cnt + CW'(1);
                WAIT_GO_LOW: if (!bus.go) begin
                    dr_r  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
